// File: rtl/tbx_mem_model.sv
// Byte-enabled word RAM behind the TBX BFM arbiter: clocked preload port, then fixed-latency core responses.
// Optional TBX_MEM_INIT_TRACK_EN flags reads of never-written words (DEADBEEF + mem_err).
module tbx_mem_model #(
    parameter int MEM_SIZE = 65536,
    parameter int LATENCY  = 1,
    parameter int AW       = $clog2(MEM_SIZE) - 2
) (
    input  logic          clk_sys,
    input  logic          rst_sys_n,
    input  logic          mem_req,
    input  logic          mem_write,
    input  logic [3:0]    mem_be,
    input  logic [31:0]   mem_addr,
    input  logic [31:0]   mem_wdata,
    output logic          mem_rvalid,
    output logic [31:0]   mem_rdata,
    input  logic          load_valid,
    output logic          load_ready,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data,
    input  logic          load_last,
    output logic          load_done,
    output logic [AW:0]   load_count,
    output logic          mem_err
);
    localparam int          DEPTH     = 2 ** AW;
    localparam logic [AW:0] COUNT_MAX = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] COUNT_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

    state_t        state_reg;
    logic          load_ready_reg;
    logic          load_done_reg;
    logic [AW:0]   load_count_reg;
    logic          load_hs;
    logic          accept;
    logic          rd_en;
    logic          wr_en;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] wr_addr;
    logic [3:0]    wr_be;
    logic [31:0]   wr_data;
    logic [31:0]   rd_word;
    logic          s0_valid_reg;
    logic          s0_read_reg;
    logic [31:0]   s0_data;
    logic          s0_err;
    logic          unused_addr_bits;

    // Address bits outside the word index alias by design.
    assign unused_addr_bits = ^{mem_addr[31:AW+2], mem_addr[1:0]};

    assign load_hs = load_valid & load_ready_reg;
    assign accept  = mem_req & (state_reg == S_RUN);
    assign rd_en   = accept & ~mem_write;
    assign rd_addr = mem_addr[AW+1:2];

    // Preload and core writes live in disjoint states, so they share one write port.
    assign wr_en   = load_hs | (accept & mem_write);
    assign wr_addr = load_hs ? load_addr : rd_addr;
    assign wr_be   = load_hs ? 4'hF : mem_be;
    assign wr_data = load_hs ? load_data : mem_wdata;

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            state_reg      <= S_IDLE;
            load_ready_reg <= 1'b0;
            load_done_reg  <= 1'b0;
            load_count_reg <= '0;
        end else begin
            if (load_hs && load_count_reg != COUNT_MAX)
                load_count_reg <= load_count_reg + COUNT_ONE;
            case (state_reg)
                S_IDLE, S_LOAD: begin
                    load_ready_reg <= 1'b1;
                    if (load_hs) begin
                        if (load_last) begin
                            state_reg      <= S_RUN;
                            load_ready_reg <= 1'b0;
                            load_done_reg  <= 1'b1;
                        end else begin
                            state_reg <= S_LOAD;
                        end
                    end
                end
                S_RUN: begin
                    load_ready_reg <= 1'b0;
                    load_done_reg  <= 1'b1;
                end
                default: begin
                    state_reg      <= S_IDLE;
                    load_ready_reg <= 1'b0;
                end
            endcase
        end
    end

    assign load_ready = load_ready_reg;
    assign load_done  = load_done_reg;
    assign load_count = load_count_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] lane_rd_reg;

            always_ff @(posedge clk_sys) begin
                if (wr_en && wr_be[gi])
                    lane_mem[wr_addr] <= wr_data[gi*8 +: 8];
                if (rd_en)
                    lane_rd_reg <= lane_mem[rd_addr];
            end

            assign rd_word[gi*8 +: 8] = lane_rd_reg;
        end
    endgenerate

    // Stage 0 of the response pipe is the RAM read register itself.
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            s0_valid_reg <= 1'b0;
            s0_read_reg  <= 1'b0;
        end else begin
            s0_valid_reg <= accept;
            s0_read_reg  <= rd_en;
        end
    end

`ifdef TBX_MEM_INIT_TRACK_EN
    logic [DEPTH-1:0] written_reg;
    logic             s0_unwritten_reg;

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            written_reg      <= '0;
            s0_unwritten_reg <= 1'b0;
        end else begin
            if (wr_en)
                written_reg[wr_addr] <= 1'b1;
            s0_unwritten_reg <= rd_en & ~written_reg[rd_addr];
        end
    end

    assign s0_err  = s0_read_reg & s0_unwritten_reg;
    assign s0_data = !s0_read_reg     ? 32'h0 :
                     s0_unwritten_reg ? 32'hDEADBEEF : rd_word;
`else
    assign s0_err  = 1'b0;
    assign s0_data = s0_read_reg ? rd_word : 32'h0;
`endif

    generate
        if (LATENCY == 1) begin : g_lat1
            assign mem_rvalid = s0_valid_reg;
            assign mem_rdata  = s0_data;
            assign mem_err    = s0_err;
        end else begin : g_tail
            logic [LATENCY-2:0] v_reg;
            logic [LATENCY-2:0] e_reg;
            logic [31:0]        d_reg [LATENCY-1];

            always_ff @(posedge clk_sys or negedge rst_sys_n) begin
                if (!rst_sys_n) begin
                    v_reg <= '0;
                    e_reg <= '0;
                    for (int i = 0; i < LATENCY - 1; i++)
                        d_reg[i] <= '0;
                end else begin
                    v_reg[0] <= s0_valid_reg;
                    e_reg[0] <= s0_err;
                    d_reg[0] <= s0_data;
                    for (int i = 1; i < LATENCY - 1; i++) begin
                        v_reg[i] <= v_reg[i-1];
                        e_reg[i] <= e_reg[i-1];
                        d_reg[i] <= d_reg[i-1];
                    end
                end
            end

            assign mem_rvalid = v_reg[LATENCY-2];
            assign mem_rdata  = d_reg[LATENCY-2];
            assign mem_err    = e_reg[LATENCY-2];
        end
    endgenerate
endmodule
